// File: rtl/final_error_detector_pkg.sv
// Shared constants and helpers for the Razor-style timing-error detector.
package final_error_detector_pkg;

  // Default width of the optional saturating error counter.
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Saturating increment for a counter of the given width (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/final_error_detector_bit.sv
// One monitored bit: rising-edge main flop, falling-edge shadow flop and the
// live mismatch between the bus and the last rising-edge sample.
module final_error_detector_bit (
  input  logic clk,
  input  logic reset,
  input  logic data,
  output logic main_q,
  output logic shadow_q,
  output logic mismatch
);

  // Main sample taken at the launch edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) main_q <= 1'b0;
    else       main_q <= data;
  end

  // Shadow sample taken at the end of the clock-high detection window.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) shadow_q <= 1'b0;
    else       shadow_q <= data;
  end

  assign mismatch = data ^ main_q;

endmodule

// File: rtl/final_error_detector.sv
// Razor-style timing-error detector. The clock-high phase is the detection
// window: a net change of data between the rising and falling edge flags a
// late transition, selects the shadow sample on q and raises error one cycle.
// Optional feature: define ERROR_COUNT_EN to add the saturating err_count port.
module final_error_detector
  import final_error_detector_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic             error,
  output logic             transition,
  output logic [WIDTH-1:0] q
`ifdef ERROR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  if (WIDTH < 1 || CNT_W < 1 || CNT_W > 32) begin : g_param_check
    $error("final_error_detector: WIDTH must be >= 1 and CNT_W in 1..32");
  end

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] mismatch;
  logic             win_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    final_error_detector_bit u_bit (
      .clk      (clk),
      .reset    (reset),
      .data     (data[i]),
      .main_q   (main_q[i]),
      .shadow_q (shadow_q[i]),
      .mismatch (mismatch[i])
    );
  end

  // Capture whether the window ended with a net difference from the main sample.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) win_err <= 1'b0;
    else       win_err <= |mismatch;
  end

  // Report the window result as a one-cycle flag aligned to the next launch edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error <= 1'b0;
    else       error <= win_err;
  end

  // Masked during reset so an active bus cannot leak through the cleared main flop.
  assign transition = reset ? 1'b0 : |mismatch;
  assign q          = win_err ? shadow_q : main_q;

`ifdef ERROR_COUNT_EN
  logic [CNT_W-1:0] err_count_q;

  // Count violations on the same edge that raises error, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_count_q <= '0;
    else if (win_err) err_count_q <= CNT_W'(sat_inc(32'(err_count_q), CNT_W));
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_final_error_detector.sv
// Bench for final_error_detector: timed directed scenarios, then randomized
// windows checked through expected-value queues drained by monitor processes.
module tb_final_error_detector;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned N_RAND = 300;

  logic             clk = 1'b1;
  logic             reset;
  logic [WIDTH-1:0] data;
  logic             error;
  logic             transition;
  logic [WIDTH-1:0] q;
`ifdef ERROR_COUNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic             exp_trans_q[$];
  logic [WIDTH-1:0] exp_q_q[$];
  logic             exp_err_q[$];

  // Posedges at 10, 20, ...; negedges at 5, 15, ...
  always #5 clk = ~clk;

  final_error_detector #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .error      (error),
    .transition (transition),
    .q          (q)
`ifdef ERROR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_until(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  // Monitors: each pops its own queue at a fixed point away from the edges.
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && exp_err_q.size() > 0) check("rand_error", 32'(error), 32'(exp_err_q.pop_front()));
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (mon_en && exp_trans_q.size() > 0)
      check("rand_transition", 32'(transition), 32'(exp_trans_q.pop_front()));
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en && exp_q_q.size() > 0) check("rand_q", 32'(q), 32'(exp_q_q.pop_front()));
  end

  initial begin
    logic [WIDTH-1:0] main_m, mid, w, l;
    logic             win;
    int unsigned      cnt_m;
    int unsigned      cnt_max;
    cnt_m   = 0;
    cnt_max = (1 << CNT_W) - 1;

    // Reset held 0..12 while the bus moves.
    reset = 1'b1;
    data  = '0;
    wait_until(3);
    check("rst_q", 32'(q), 0);
    check("rst_error", 32'(error), 0);
    check("rst_transition", 32'(transition), 0);
    wait_until(7);  data = 8'hFF;
    wait_until(8);
    check("rst_q_busy", 32'(q), 0);
    check("rst_transition_busy", 32'(transition), 0);
    wait_until(11);
    check("rst_error_edge", 32'(error), 0);
    check("rst_q_edge", 32'(q), 0);
    wait_until(12); data = 8'h00; reset = 1'b0;

    // Setup-side change before posedge 30: clean capture.
    wait_until(27); data = 8'h01;
    wait_until(31);
    check("setup_transition", 32'(transition), 0);
    check("setup_q", 32'(q), 32'h01);
    wait_until(36);
    check("setup_error", 32'(error), 0);
    check("setup_q_low", 32'(q), 32'h01);

    // In-window change at 42: shadow on q from 45, error during 50..60.
    wait_until(42); data = 8'h00;
    wait_until(43); check("win_transition", 32'(transition), 1);
    wait_until(46); check("win_q_shadow", 32'(q), 32'h00);
    wait_until(49); check("win_error_early", 32'(error), 0);
    wait_until(51); check("win_error", 32'(error), 1);
    wait_until(56); check("win_q_after", 32'(q), 32'h00);
    wait_until(61); check("win_error_one_cycle", 32'(error), 0);

    // Low-phase toggle at 67: no error, main updates at 70.
    wait_until(67); data = 8'h01;
    wait_until(68); check("low_transition", 32'(transition), 1);
    wait_until(71); check("low_transition_clear", 32'(transition), 0);
    wait_until(77); data = 8'h00;
    wait_until(81); check("low_error", 32'(error), 0);

    // Bit 5 flips inside the 80..85 window.
    wait_until(82); data = 8'h20;
    wait_until(86); check("bit5_q", 32'(q), 32'h20);
    wait_until(91); check("bit5_error", 32'(error), 1);
`ifdef ERROR_COUNT_EN
    check("count_two", 32'(err_count), 2);
`endif
    wait_until(101); check("bit5_error_clear", 32'(error), 0);

    // Toggle-back inside one window is not flagged.
    wait_until(102); data = 8'h00;
    wait_until(103); data = 8'h20;
    wait_until(106); check("glitch_q", 32'(q), 32'h20);
    wait_until(111); check("glitch_error", 32'(error), 0);

    // Pending window error cleared by reset before it is reported.
    wait_until(112); data = 8'h21;
    wait_until(116); check("pend_q_shadow", 32'(q), 32'h21);
    wait_until(117); reset = 1'b1;
    wait_until(118); reset = 1'b0;
    wait_until(119);
    check("pend_q_cleared", 32'(q), 0);
    check("pend_error_rst", 32'(error), 0);
`ifdef ERROR_COUNT_EN
    check("count_rst", 32'(err_count), 0);
`endif
    wait_until(121); check("pend_error_dropped", 32'(error), 0);
    wait_until(126); check("pend_q_main", 32'(q), 32'h21);
    wait_until(131); check("pend_error_late", 32'(error), 0);

    // Randomized windows: glitch, settle value at window end, low-phase value.
    mon_en = 1'b1;
    for (int n = 0; n < N_RAND; n++) begin
      @(posedge clk);
      main_m = data;
      #2;
      mid  = WIDTH'($urandom);
      data = mid;
      exp_trans_q.push_back(mid != main_m);
      #2;
      w    = ($urandom_range(1, 0) == 1) ? main_m : WIDTH'($urandom);
      data = w;
      win  = (w != main_m);
      exp_q_q.push_back(win ? w : main_m);
      exp_err_q.push_back(win);
      if (win && cnt_m < cnt_max) cnt_m++;
      #3;
      l    = ($urandom_range(1, 0) == 1) ? w : WIDTH'($urandom);
      data = l;
    end

    @(posedge clk);
    #3;
    check("drain_error_queue", 32'(exp_err_q.size()), 0);
    check("drain_q_queue", 32'(exp_q_q.size()), 0);
    check("drain_trans_queue", 32'(exp_trans_q.size()), 0);
`ifdef ERROR_COUNT_EN
    check("count_final", 32'(err_count), cnt_m);
    reset = 1'b1;
    #1;
    check("count_reset", 32'(err_count), 0);
    reset = 1'b0;
`endif
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/final_error_detector.md
Name: final_error_detector

Overview:
- Razor-style timing-error detector for the error-resilient processor pipeline.
- Samples a data bus on the rising clock edge (main flop) and again on the falling edge (shadow flop). The clock-high phase is the detection window.
- Any change of data inside that window is a late-arriving transition. It raises `error` for one cycle and selects the shadow value as the corrected output.

Parameters:
- WIDTH, 1, width of the monitored data bus in bits.
- CNT_W, 8, width of the error counter (used only when ERROR_COUNT_EN is defined).

Ports:
- clk  in  1  single clock; rising edge = launch/sample, falling edge = end of detection window.
- reset  in  1  asynchronous, active-high reset.
- data  in  WIDTH  monitored data (pipeline stage input).
- error  out  1  registered timing-error flag, high for one cycle per detected violation.
- transition  out  1  combinational: high while data differs from the last rising-edge sample.
- q  out  WIDTH  corrected data; main sample normally, shadow sample when a window error was detected.
- err_count  out  CNT_W  saturating error count (present only with ERROR_COUNT_EN).

Behaviour:
- Interface: one clock, `clk`; reset `reset` is asynchronous and active-high.
- Reset (asynchronous, active-high) clears `main_q`, `shadow_q`, `win_err`, `error` and `err_count` to 0 immediately on assertion. This applies to both the rising-edge and the falling-edge flops.
- While `reset` is high, all outputs are 0 (q=0, transition=0, error=0).
- Posedge k: `main_q <= data`; `error <= win_err`.
- Negedge k: `shadow_q <= data`; `win_err <= |(data ^ main_q)`.
  - This flags any bit that changed between posedge k and negedge k.
- Error latency: a transition in the high phase after posedge k gives `error=1` from posedge k+1 to posedge k+2 (exactly one cycle).
- Data changes during the low phase do not flag an error. They are normal setup-side changes captured by the next posedge.
- A transition exactly at a clock edge is a race. The bench must not rely on it.
- `transition = |(data ^ main_q)`, purely combinational, no clock gating.
- `q = win_err ? shadow_q : main_q` (combinational mux).
- Multiple toggles in one window that return data to the `main_q` value are not flagged (net mismatch only).
- Consecutive windows with violations keep `error` high for consecutive cycles.
- Reset asserted mid-window clears a pending `win_err`, so no error is reported after release.
- No handshake; the block is free-running every cycle.

Optional Feature:
- Macro `ERROR_COUNT_EN`.
- When defined: port `err_count[CNT_W-1:0]` exists and increments on every posedge where `win_err=1` (same condition that sets `error`). It saturates at all-ones and clears on reset.
- When not defined: the port and counter logic are absent; all other behaviour is unchanged.

Decomposition:
- Package `final_error_detector_pkg`: default CNT_W constant and a saturating-increment function.
- One natural sub-module, `final_error_detector_bit`, one instance per bit. It holds the main flop, shadow flop and per-bit mismatch.
- The top OR-reduces the mismatches, registers `win_err`/`error`, builds the mux and the optional counter.

Test Plan (period 10, posedges at 10,20,30…, negedges at 5,15,25…):
- Reset held 0–12 with data toggling every 7 -> error=0, q=0, transition=0 throughout reset.
- WIDTH=1, data 0->1 at t=3 (before posedge 10) -> main_q=1 at 10, win_err=0, error stays 0.
- data 0->1 at t=12 (inside window 10–15) -> win_err=1 at 15, q=1 from 15, error=1 during 20–30, then 0.
- data toggles at t=17 (low phase) -> no error; main_q updates at 20.
- WIDTH=8, data 0x00 stable, bit 5 flips at t=22 -> error=1 during 30–40, q=0x20 from 25.
- Reset pulsed at t=13 after an in-window toggle at t=12 -> win_err cleared, error never rises.
- With ERROR_COUNT_EN and CNT_W=2: five consecutive in-window violations -> err_count=3 (saturated); reset returns it to 0.
